// File: rtl/apb_master.sv
// APB3 initiator: turns one valid/ready command into one SETUP/ACCESS transfer and one response pulse.
// Latency: accept edge E0, SETUP E0..E1, ACCESS from E1, response pulse 1 cycle after ready (min 4 cycles/transfer).
// Backpressure: cmd_ready_out is high only in IDLE; rsp_valid_out is a single-cycle pulse that cannot be stalled.
//
// Ports:
//   apb_clk_in / apb_rstn_in          clock, synchronous active-low reset
//   cmd_valid_in / cmd_ready_out      command handshake; cmd_write_in/cmd_addr_in/cmd_wdata_in captured on accept
//   rsp_valid_out                     response pulse with rsp_rdata_out / rsp_slverr_out / rsp_timeout_out
//   apb_*_out / apb_*_in              APB3 bus (PADDR, PSEL, PENABLE, PWRITE, PWDATA, PRDATA, PREADY, PSLVERR)
module apb_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      apb_clk_in,
    input  logic                      apb_rstn_in,
    input  logic                      cmd_valid_in,
    output logic                      cmd_ready_out,
    input  logic                      cmd_write_in,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
    output logic                      rsp_valid_out,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
    output logic                      rsp_slverr_out,
    output logic                      rsp_timeout_out,
    output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
    output logic                      apb_psel_out,
    output logic                      apb_penable_out,
    output logic                      apb_write_out,
    output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
    input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
    input  logic                      apb_ready_in,
    input  logic                      apb_slverr_in
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // Abort fires on the edge that would record the TIMEOUT_CYCLES-th unready ACCESS cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_slverr_q, rsp_slverr_d;
    logic                      rsp_timeout_q, rsp_timeout_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Outputs are registered, so each *_d below is the value for the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        addr_d        = addr_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        write_d       = write_q;
        wdata_d       = wdata_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                // Handshake uses the registered ready, so the first cycle after reset never accepts.
                if (cmd_valid_in && cmd_ready_q) begin
                    write_d     = cmd_write_in;
                    addr_d      = cmd_addr_in;
                    wdata_d     = cmd_wdata_in;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb_ready_in) begin
                    rsp_rdata_d   = write_q ? '0 : apb_rdata_in;
                    rsp_slverr_d  = apb_slverr_in;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d         = cnt_q + 8'd1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d       = 8'd0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_clk_in) begin
        if (!apb_rstn_in) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            addr_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            addr_q        <= addr_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
        end
    end

    assign cmd_ready_out   = cmd_ready_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_rdata_out   = rsp_rdata_q;
    assign rsp_slverr_out  = rsp_slverr_q;
    assign rsp_timeout_out = rsp_timeout_q;
    assign apb_addr_out    = addr_q;
    assign apb_psel_out    = psel_q;
    assign apb_penable_out = penable_q;
    assign apb_write_out   = write_q;
    assign apb_wdata_out   = wdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait write, waited read, slave error, timeout, timeout boundary, mid-transfer reset.
// Latency: checks are cycle-exact against the accept edge.
// Backpressure: the bench only presents a command while cmd_ready_out is high.
module tb_apb_master;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [31:0] apb_addr;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_write;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata;
    logic        apb_ready;
    logic        apb_slverr;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .apb_clk_in      (clk),
        .apb_rstn_in     (rstn),
        .cmd_valid_in    (cmd_valid),
        .cmd_ready_out   (cmd_ready),
        .cmd_write_in    (cmd_write),
        .cmd_addr_in     (cmd_addr),
        .cmd_wdata_in    (cmd_wdata),
        .rsp_valid_out   (rsp_valid),
        .rsp_rdata_out   (rsp_rdata),
        .rsp_slverr_out  (rsp_slverr),
        .rsp_timeout_out (rsp_timeout),
        .apb_addr_out    (apb_addr),
        .apb_psel_out    (apb_psel),
        .apb_penable_out (apb_penable),
        .apb_write_out   (apb_write),
        .apb_wdata_out   (apb_wdata),
        .apb_rdata_in    (apb_rdata),
        .apb_ready_in    (apb_ready),
        .apb_slverr_in   (apb_slverr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it; inputs and samples both live here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'h0;
        cmd_addr  = 32'h0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, rsp_valid}, 64'd1);
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        apb_rdata = 32'h0; apb_ready = 1'b0; apb_slverr = 1'b0;
        tick(); tick();
        chk("rst_outputs", {cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, apb_psel, apb_penable, apb_write}, 64'd0);
        chk("rst_buses", {apb_addr, apb_wdata | rsp_rdata}, 64'd0);
        rstn = 1'b1;
        tick();
        chk("rst_rel_ready", {63'd0, cmd_ready}, 64'd1);

        // Zero-wait write; ready held high through SETUP must be ignored there.
        apb_ready = 1'b1;
        issue(1'b1, 32'hA030_0004, 32'h0000_00A5);
        chk("wr_setup_ctl", {cmd_ready, apb_psel, apb_penable, apb_write}, 64'b0101);
        chk("wr_setup_bus", {apb_addr, apb_wdata}, {32'hA030_0004, 32'h0000_00A5});
        tick();
        chk("wr_access_ctl", {rsp_valid, apb_psel, apb_penable, apb_write}, 64'b0111);
        chk("wr_access_bus", {apb_addr, apb_wdata}, {32'hA030_0004, 32'h0000_00A5});
        apb_rdata = 32'hFFFF_0000;
        tick();
        chk("wr_resp_ctl", {rsp_valid, rsp_slverr, rsp_timeout, apb_psel, apb_penable, cmd_ready}, 64'b100000);
        chk("wr_resp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("wr_hold_bus", {apb_addr, apb_wdata}, {32'hA030_0004, 32'h0000_00A5});
        tick();
        chk("wr_after_ctl", {rsp_valid, cmd_ready}, 64'b01);

        // Read with 3 wait states; bus data is junk until ready.
        apb_ready = 1'b0; apb_rdata = 32'hDEAD_DEAD;
        issue(1'b0, 32'hA030_0010, 32'h0);
        chk("rd_setup_ctl", {apb_psel, apb_penable, apb_write}, 64'b100);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rd_wait%0d", i), {rsp_valid, apb_psel, apb_penable}, 64'b011);
        end
        apb_ready = 1'b1; apb_rdata = 32'h1234_5678;
        tick();
        chk("rd_resp_ctl", {rsp_valid, apb_psel, apb_penable, cmd_ready, rsp_slverr, rsp_timeout}, 64'b100000);
        chk("rd_resp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
        apb_ready = 1'b0; apb_rdata = 32'h0;
        tick();
        chk("rd_after_ctl", {rsp_valid, cmd_ready}, 64'b01);
        chk("rd_rdata_hold", {32'd0, rsp_rdata}, 64'h1234_5678);

        // Slave error with ready.
        issue(1'b0, 32'hA030_00FC, 32'h0);
        chk("err_setup_addr", {32'd0, apb_addr}, 64'hA030_00FC);
        tick();
        apb_ready = 1'b1; apb_slverr = 1'b1; apb_rdata = 32'hBAD0_0001;
        tick();
        chk("err_resp_ctl", {rsp_valid, rsp_slverr, rsp_timeout}, 64'b110);
        chk("err_resp_rdata", {32'd0, rsp_rdata}, 64'hBAD0_0001);
        apb_ready = 1'b0;
        tick();

        // Timeout: slverr and rdata on the bus without ready must not leak into the response.
        apb_rdata = 32'hFFFF_FFFF;
        issue(1'b0, 32'hA030_0020, 32'h0);
        tick();
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk($sformatf("to_access%0d", i), {rsp_valid, apb_psel, apb_penable}, 64'b011);
        end
        tick();
        chk("to_resp_ctl", {rsp_valid, rsp_timeout, rsp_slverr, apb_psel, apb_penable}, 64'b11000);
        chk("to_resp_rdata", {32'd0, rsp_rdata}, 64'd0);
        apb_slverr = 1'b0; apb_rdata = 32'h0;
        tick();
        chk("to_after_ready", {rsp_valid, cmd_ready}, 64'b01);
        apb_ready = 1'b1;
        issue(1'b1, 32'hA030_0024, 32'h0000_0055);
        wait_rsp("to_next_rsp");
        chk("to_next_flags", {rsp_timeout, rsp_slverr}, 64'b00);
        apb_ready = 1'b0;
        tick();

        // Boundary: ready on exactly the 16th ACCESS cycle.
        issue(1'b0, 32'hA030_0028, 32'h0);
        tick();
        for (int i = 2; i <= 16; i++) tick();
        chk("bnd_still_access", {rsp_valid, apb_penable}, 64'b01);
        apb_ready = 1'b1; apb_rdata = 32'h0BAD_F00D;
        tick();
        chk("bnd_resp_ctl", {rsp_valid, rsp_timeout, rsp_slverr}, 64'b100);
        chk("bnd_resp_rdata", {32'd0, rsp_rdata}, 64'h0BAD_F00D);
        apb_ready = 1'b0; apb_rdata = 32'h0;
        tick();

        // Reset during a wait state, then back-to-back writes.
        issue(1'b1, 32'hA030_0030, 32'h0000_0077);
        tick();
        tick();
        chk("mrst_pre_wait", {apb_psel, apb_penable}, 64'b11);
        rstn = 1'b0;
        tick();
        chk("mrst_ctl", {apb_psel, apb_penable, rsp_valid, cmd_ready}, 64'b0000);
        rstn = 1'b1;
        tick();
        chk("mrst_rel", {rsp_valid, cmd_ready, apb_psel}, 64'b010);
        tick();
        chk("mrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        apb_ready = 1'b1;
        issue(1'b1, 32'hA030_0040, 32'h0000_1111);
        wait_rsp("b2b_rsp0");
        tick();
        chk("b2b_ready0", {63'd0, cmd_ready}, 64'd1);
        issue(1'b1, 32'hA030_0044, 32'h0000_2222);
        chk("b2b_setup_bus", {apb_addr, apb_wdata}, {32'hA030_0044, 32'h0000_2222});
        wait_rsp("b2b_rsp1");
        chk("b2b_flags", {rsp_timeout, rsp_slverr, rsp_rdata}, 64'd0);
        apb_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that converts a simple valid/ready command interface into single APB3 transfers to register slaves such as the UART register block. It sits between an on-chip controller (test sequencer, DMA, or bus bridge) and the APB segment. It owns the SETUP/ACCESS phasing, wait-state handling, error capture and a slave-hang timeout, and returns one response pulse per command.

## Interface
Parameters:
- APB_ADDR_WIDTH, 32, width of address path
- APB_DATA_WIDTH, 32, width of read/write data
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without ready before abort; legal 1..255

Ports:
- apb_clk_in  input  1  single clock; all logic on rising edge
- apb_rstn_in  input  1  reset, synchronous, active-low
- cmd_valid_in  input  1  command present
- cmd_ready_out  output  1  block can accept command
- cmd_write_in  input  1  1 = write, 0 = read
- cmd_addr_in  input  APB_ADDR_WIDTH  target address
- cmd_wdata_in  input  APB_DATA_WIDTH  write data
- rsp_valid_out  output  1  one-cycle response pulse
- rsp_rdata_out  output  APB_DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_slverr_out  output  1  slave signalled error
- rsp_timeout_out  output  1  transfer aborted by timeout
- apb_addr_out  output  APB_ADDR_WIDTH  PADDR
- apb_psel_out  output  1  PSEL
- apb_penable_out  output  1  PENABLE
- apb_write_out  output  1  PWRITE
- apb_wdata_out  output  APB_DATA_WIDTH  PWDATA
- apb_rdata_in  input  APB_DATA_WIDTH  PRDATA
- apb_ready_in  input  1  PREADY
- apb_slverr_in  input  1  PSLVERR

## Operation
- All outputs are registered. Reset value of every output is 0; state = IDLE; the timeout counter is 0.
- FSM states are IDLE, SETUP, ACCESS and RESP. Encoding is free.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in & cmd_ready_out, capture write/addr/wdata into apb_write_out/apb_addr_out/apb_wdata_out and go to SETUP.
- SETUP:
  - psel = 1, penable = 0, cmd_ready = 0.
  - Always goes to ACCESS after one cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - Each edge with apb_ready_in = 0 increments the counter.
  - On an edge with apb_ready_in = 1:
    - capture rsp_rdata_out = apb_rdata_in for reads, 0 for writes;
    - capture rsp_slverr_out = apb_slverr_in;
    - go to RESP.
  - If the counter reaches TIMEOUT_CYCLES while ready is still 0:
    - abort and go to RESP;
    - set rsp_timeout_out = 1, rsp_slverr_out = 0, rsp_rdata_out = 0.
- RESP:
  - psel = 0, penable = 0, rsp_valid_out = 1 for exactly one cycle.
  - Clear the counter and go to IDLE.
- rsp_rdata/slverr/timeout hold their values until the next RESP. rsp_valid_out is a pulse with no backpressure.
- apb_addr/write/wdata are stable from SETUP through the end of ACCESS and retain their last values in IDLE.
- apb_ready_in and apb_slverr_in are ignored outside ACCESS. apb_slverr_in is sampled only with ready.

## Timing
- Edge E0 accepts the command.
- SETUP is visible in cycle E0..E1 and ACCESS from E1.
- With zero wait states, ready is sampled at E2, RESP is in E2..E3, and cmd_ready is high again from E3.
- Minimum 4 cycles per transfer. Each wait state adds 1 cycle.
- Timeout: ACCESS lasts at most TIMEOUT_CYCLES cycles. The response pulse follows in the next cycle.
- Ready arriving on the same edge the counter hits the limit: ready wins, and this is a normal completion.
- Reset:
  - apb_rstn_in low at any edge, including mid-transfer, forces all outputs to 0 and state to IDLE on that edge.
  - No response is issued for the interrupted command.
  - cmd_ready_out = 1 from the first edge after reset deasserts.
- No command pipelining. cmd_valid_in outside IDLE is not accepted and must be held by the source.

## Test plan
- Write, zero wait states: cmd write addr 0xA030_0004, data 0x0000_00A5 -> psel in SETUP, penable next cycle, addr/wdata/write=1 stable for both. rsp_valid at cycle 3 after accept, slverr=0, timeout=0, rdata=0.
- Read with 3 wait states: slave returns 0x1234_5678 when ready -> ACCESS lasts 4 cycles. rsp_rdata=0x1234_5678, rsp_valid exactly one cycle, cmd_ready back 1 cycle after it.
- Slave error: read of 0xA030_00FC, slave asserts ready and slverr together -> rsp_slverr=1, timeout=0, rdata captured from bus.
- Timeout: TIMEOUT_CYCLES=16, ready held 0 -> psel/penable drop after 16 ACCESS cycles. rsp_timeout=1, slverr=0, rdata=0. A second command is then accepted normally.
- Boundary: ready asserted on exactly the 16th ACCESS cycle -> normal completion, timeout=0.
- Reset mid-ACCESS: assert apb_rstn_in low during a wait state -> next edge psel=penable=0, rsp_valid never asserts. After release, cmd_ready=1 and a back-to-back write completes.
